// File: rtl/alu_cmd_issuer_pkg.sv
// alu_cmd_issuer_pkg
// Shared system-controller definitions for the ALU command path:
//   - FSM state encoding of the command issuer (3-bit)
//   - default command opcodes
//   - ALU unit select codes carried in alu_fun[3:2]
package alu_cmd_issuer_pkg;

   localparam logic [7:0] CMD_ALU_OP_DEFAULT  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP_DEFAULT = 8'hDD;

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StGetA    = 3'd1,
      StGetB    = 3'd2,
      StGetFun  = 3'd3,
      StExec    = 3'd4,
      StWaitRes = 3'd5,
      StSendLo  = 3'd6,
      StSendHi  = 3'd7
   } issuer_state_e;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_if
// Bundle of the byte-stream, ALU and transmit signals around the command issuer.
//   master : the issuer (consumes rx/alu result/tx_busy, drives operands, enable, tx, err)
//   slave  : the surrounding datapath (UART RX/TX and ALU)
interface alu_cmd_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [3:0]  alu_fun;
   logic        alu_en;
   logic [15:0] alu_out;
   logic        alu_out_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_busy;
   logic        err;

   modport master (
      input  rx_data, rx_valid, alu_out, alu_out_valid, tx_busy,
      output alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, err
   );

   modport slave (
      output rx_data, rx_valid, alu_out, alu_out_valid, tx_busy,
      input  alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, err
   );

endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
// Collects ALU command frames byte by byte, issues a one-cycle ALU enable with the
// captured function code, waits (bounded) for the 16-bit result and returns it to the
// transmitter low byte first.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_cmd_if.master (rx byte stream, ALU operands/function/enable,
//           ALU result, tx byte stream, err pulse)
// All outputs are registered.
module alu_cmd_issuer
   import alu_cmd_issuer_pkg::*;
#(
   parameter logic [7:0]  CMD_ALU_OP  = CMD_ALU_OP_DEFAULT,
   parameter logic [7:0]  CMD_ALU_NOP = CMD_ALU_NOP_DEFAULT,
   parameter int unsigned RES_TIMEOUT = 15
) (
   input logic       clk,
   input logic       rst_n,
   alu_cmd_if.master bus
);

   localparam int unsigned CNT_W = $clog2(RES_TIMEOUT + 1);
   // Counter value seen in the last allowed WAIT_RES cycle (counter starts at 0).
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RES_TIMEOUT - 1);

   issuer_state_e    state;
   logic [15:0]      result;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         result      <= '0;
         cnt         <= '0;
         bus.alu_a   <= '0;
         bus.alu_b   <= '0;
         bus.alu_fun <= '0;
         bus.alu_en  <= 1'b0;
         bus.tx_data <= '0;
         bus.tx_valid <= 1'b0;
         bus.err     <= 1'b0;
      end else begin
         bus.alu_en <= 1'b0;
         bus.err    <= 1'b0;

         unique case (state)
            StIdle: begin
               if (bus.rx_valid) begin
                  if (bus.rx_data == CMD_ALU_OP) begin
                     state <= StGetA;
                  end else if (bus.rx_data == CMD_ALU_NOP) begin
                     state <= StGetFun;
                  end else begin
                     bus.err <= 1'b1;
                  end
               end
            end

            StGetA: begin
               if (bus.rx_valid) begin
                  bus.alu_a <= bus.rx_data;
                  state     <= StGetB;
               end
            end

            StGetB: begin
               if (bus.rx_valid) begin
                  bus.alu_b <= bus.rx_data;
                  state     <= StGetFun;
               end
            end

            StGetFun: begin
               if (bus.rx_valid) begin
                  // Enable is raised together with the capture so it lands in EXEC.
                  bus.alu_fun <= bus.rx_data[3:0];
                  bus.alu_en  <= 1'b1;
                  state       <= StExec;
               end
            end

            StExec: begin
               cnt   <= '0;
               state <= StWaitRes;
            end

            StWaitRes: begin
               // A result in the expiring cycle still wins over the timeout.
               if (bus.alu_out_valid) begin
                  result       <= bus.alu_out;
                  bus.tx_data  <= bus.alu_out[7:0];
                  bus.tx_valid <= 1'b1;
                  state        <= StSendLo;
               end else if (cnt == CNT_LAST) begin
                  bus.err <= 1'b1;
                  state   <= StIdle;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            StSendLo: begin
               if (!bus.tx_busy) begin
                  bus.tx_data <= result[15:8];
                  state       <= StSendHi;
               end else begin
                  bus.tx_data <= result[7:0];
               end
            end

            StSendHi: begin
               if (!bus.tx_busy) begin
                  bus.tx_valid <= 1'b0;
                  state        <= StIdle;
               end
            end

            default: state <= StIdle;
         endcase

         // Bytes arriving while a command is in flight are dropped, not queued.
         if (bus.rx_valid && (state inside {StExec, StWaitRes, StSendLo, StSendHi})) begin
            bus.err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer
// Directed bench for alu_cmd_issuer. A frame-level model (stored operands, queue of
// expected ALU issues, queue of expected tx bytes) is checked every cycle by one
// compare process; directed steps pin cycle timing with literal expectations.
module tb_alu_cmd_issuer;
   import alu_cmd_issuer_pkg::*;

   localparam int unsigned T = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   alu_cmd_if bus();

   alu_cmd_issuer #(
      .CMD_ALU_OP  (8'hCC),
      .CMD_ALU_NOP (8'hDD),
      .RES_TIMEOUT (T)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   int err_exp = 0;

   // Model state: operands/function the ALU must see, bytes the transmitter must see.
   logic [7:0]  m_a = '0;
   logic [7:0]  m_b = '0;
   logic [3:0]  m_fun = '0;
   logic [19:0] exp_exec[$];
   logic [7:0]  exp_tx[$];
   logic [19:0] exec_rec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Compare process: every alu_en must match the next expected issue, and every cycle
   // with tx_valid must present the next expected byte (held while tx_busy).
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.err === 1'b1) err_seen++;
         if (bus.alu_en === 1'b1) begin
            checks++;
            if (exp_exec.size() == 0) begin
               errors++;
               $display("FAIL alu_en with no pending frame: got alu_en=1, want 0");
            end else begin
               exec_rec = exp_exec.pop_front();
               chk("alu issue {a,b,fun}", {12'h0, bus.alu_a, bus.alu_b, bus.alu_fun},
                   {12'h0, exec_rec});
            end
         end
         if (bus.tx_valid === 1'b1) begin
            checks++;
            if (exp_tx.size() == 0) begin
               errors++;
               $display("FAIL tx_valid with no pending byte: got tx_data=0x%0h, want no tx",
                        bus.tx_data);
            end else begin
               chk("tx byte", bus.tx_data, exp_tx[0]);
               if (bus.tx_busy === 1'b0) void'(exp_tx.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      step();
      bus.rx_valid = 1'b0;
   endtask

   task automatic frame_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
      m_a   = a;
      m_b   = b;
      m_fun = f[3:0];
      exp_exec.push_back({m_a, m_b, m_fun});
      send_byte(8'hCC);
      send_byte(a);
      send_byte(b);
      send_byte(f);
   endtask

   task automatic frame_nop(input logic [7:0] f);
      m_fun = f[3:0];
      exp_exec.push_back({m_a, m_b, m_fun});
      send_byte(8'hDD);
      send_byte(f);
   endtask

   task automatic reply(input logic [15:0] r);
      exp_tx.push_back(r[7:0]);
      exp_tx.push_back(r[15:8]);
      bus.alu_out       = r;
      bus.alu_out_valid = 1'b1;
      step();
      bus.alu_out_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " alu_a"}, bus.alu_a, 0);
      chk({tag, " alu_b"}, bus.alu_b, 0);
      chk({tag, " alu_fun"}, bus.alu_fun, 0);
      chk({tag, " alu_en"}, bus.alu_en, 0);
      chk({tag, " tx_data"}, bus.tx_data, 0);
      chk({tag, " tx_valid"}, bus.tx_valid, 0);
      chk({tag, " err"}, bus.err, 0);
   endtask

   initial begin
      bus.rx_data       = '0;
      bus.rx_valid      = 1'b0;
      bus.alu_out       = '0;
      bus.alu_out_valid = 1'b0;
      bus.tx_busy       = 1'b0;

      repeat (2) step();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      step();

      // Full OP frame, immediate reply
      frame_op(8'h05, 8'h03, 8'h00);
      chk("op alu_en", bus.alu_en, 1);
      chk("op alu_fun", bus.alu_fun, 4'h0);
      chk("op alu_a", bus.alu_a, 8'h05);
      chk("op alu_b", bus.alu_b, 8'h03);
      step();
      chk("op alu_en one cycle", bus.alu_en, 0);
      reply(16'h0008);
      chk("op tx_valid lo", bus.tx_valid, 1);
      chk("op tx lo", bus.tx_data, 8'h08);
      step();
      chk("op tx_valid hi", bus.tx_valid, 1);
      chk("op tx hi", bus.tx_data, 8'h00);
      step();
      chk("op tx_valid drop", bus.tx_valid, 0);
      chk("op no err", err_seen, 0);

      // NOP frame on stored operands, shift unit
      frame_nop(8'h0D);
      chk("nop alu_fun", bus.alu_fun, 4'b1101);
      chk("nop unit select", bus.alu_fun[3:2], UNIT_SHIFT);
      chk("nop alu_a kept", bus.alu_a, 8'h05);
      chk("nop alu_b kept", bus.alu_b, 8'h03);
      step();
      reply(16'h1234);
      chk("nop tx lo", bus.tx_data, 8'h34);
      step();
      chk("nop tx hi", bus.tx_data, 8'h12);
      step();
      chk("nop tx_valid drop", bus.tx_valid, 0);

      // Unknown opcode, then a normal frame (upper nibble of function ignored)
      send_byte(8'h7A);
      err_exp++;
      chk("bad opcode err", bus.err, 1);
      step();
      chk("bad opcode err one cycle", bus.err, 0);
      frame_op(8'hA0, 8'h0F, 8'h21);
      chk("after bad op alu_fun", bus.alu_fun, 4'h1);
      step();
      reply(16'h00AF);
      step();
      step();
      chk("after bad op tx_valid drop", bus.tx_valid, 0);

      // Result timeout: err exactly T+1 cycles after alu_en
      frame_op(8'h11, 8'h22, 8'h04);
      for (int k = 1; k <= int'(T); k++) begin
         step();
         chk("timeout no early err", bus.err, 0);
      end
      step();
      err_exp++;
      chk("timeout err", bus.err, 1);
      chk("timeout no tx", bus.tx_valid, 0);
      bus.alu_out       = 16'hDEAD;
      bus.alu_out_valid = 1'b1;
      step();
      bus.alu_out_valid = 1'b0;
      chk("late result ignored", bus.tx_valid, 0);
      chk("timeout err one cycle", bus.err, 0);

      // Result arriving in the expiring cycle wins
      frame_nop(8'h08);
      for (int k = 1; k <= int'(T); k++) step();
      reply(16'hCAFE);
      chk("edge result no err", bus.err, 0);
      chk("edge result tx_valid", bus.tx_valid, 1);
      chk("edge result tx lo", bus.tx_data, 8'hFE);
      step();
      chk("edge result tx hi", bus.tx_data, 8'hCA);
      step();

      // Back-pressure in SEND_LO with a dropped byte
      frame_op(8'h30, 8'h40, 8'h05);
      step();
      bus.tx_busy = 1'b1;
      reply(16'h5A6B);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            send_byte(8'h55);
            err_exp++;
            chk("dropped byte err", bus.err, 1);
         end else begin
            step();
            chk("stall no err", bus.err, 0);
         end
         chk("stall tx_valid", bus.tx_valid, 1);
         chk("stall tx lo held", bus.tx_data, 8'h6B);
      end
      bus.tx_busy = 1'b0;
      step();
      chk("release tx hi", bus.tx_data, 8'h5A);
      chk("release tx_valid", bus.tx_valid, 1);
      step();
      chk("release tx_valid drop", bus.tx_valid, 0);

      // Reset mid-frame (after GET_B)
      send_byte(8'hCC);
      send_byte(8'h11);
      send_byte(8'h22);
      chk("pre-reset alu_a", bus.alu_a, 8'h11);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async reset");
      m_a   = '0;
      m_b   = '0;
      m_fun = '0;
      step();
      step();
      rst_n = 1'b1;
      step();
      frame_nop(8'h02);
      chk("post-reset alu_en", bus.alu_en, 1);
      chk("post-reset alu_fun", bus.alu_fun, 4'h2);
      chk("post-reset alu_a", bus.alu_a, 8'h00);
      step();
      reply(16'hBEEF);
      chk("post-reset tx lo", bus.tx_data, 8'hEF);
      step();
      step();
      chk("post-reset tx_valid drop", bus.tx_valid, 0);

      step();
      chk("all issues seen", 32'(exp_exec.size()), 0);
      chk("all tx bytes seen", 32'(exp_tx.size()), 0);
      chk("err pulse count", err_seen, err_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side initiator for the ALU path. It collects ALU command frames byte-by-byte from the receive datapath and drives the ALU function code and unit enable consumed by the ALU function decoder. It captures the 16-bit ALU result and returns it as two bytes, low byte first, to the transmit datapath. It sits between the UART RX/TX byte streams and the ALU inside the system controller.

## Interface
Parameters:
- `CMD_ALU_OP`, default 8'hCC: opcode for a frame that loads both operands and then executes.
- `CMD_ALU_NOP`, default 8'hDD: opcode for a frame that executes on the stored operands.
- `RES_TIMEOUT`, default 15: maximum number of cycles spent waiting for `alu_out_valid`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe marking `rx_data` valid.
- `alu_a` out 8: operand A register.
- `alu_b` out 8: operand B register.
- `alu_fun` out 4: ALU function code. `[3:2]` drives the decoder unit select; `[1:0]` is the in-unit operation.
- `alu_en` out 1: one-cycle unit enable, driven to the decoder's `enable_unit`.
- `alu_out` in 16: ALU result.
- `alu_out_valid` in 1: result strobe.
- `tx_data` out 8: byte for the transmitter.
- `tx_valid` out 1: request to transmit `tx_data`.
- `tx_busy` in 1: transmitter is not accepting.
- `err` out 1: one-cycle error pulse (unknown opcode, timeout, or dropped byte).

## Operation
States: IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_RES, SEND_LO, SEND_HI.

- **IDLE**
  - `rx_valid` with `CMD_ALU_OP` -> GET_A.
  - `rx_valid` with `CMD_ALU_NOP` -> GET_FUN.
  - Any other byte -> pulse `err`, stay in IDLE.
- **GET_A**: on `rx_valid`, latch `alu_a`, go to GET_B.
- **GET_B**: on `rx_valid`, latch `alu_b`, go to GET_FUN.
- **GET_FUN**: on `rx_valid`, latch `alu_fun <= rx_data[3:0]` and ignore `rx_data[7:4]`; go to EXEC.
- **EXEC**: assert `alu_en` for exactly one cycle, clear the timeout counter, go to WAIT_RES.
- **WAIT_RES**
  - On `alu_out_valid`, latch the 16-bit result and go to SEND_LO.
  - When the counter reaches `RES_TIMEOUT` with no valid, pulse `err` and return to IDLE without transmitting.
- **SEND_LO**: `tx_data = result[7:0]`, `tx_valid = 1`. The byte is accepted in any cycle with `tx_valid && !tx_busy`; on acceptance go to SEND_HI.
- **SEND_HI**: same rule with `result[15:8]`; on acceptance go to IDLE.
- `rx_valid` in EXEC, WAIT_RES, SEND_LO or SEND_HI: the byte is dropped and `err` pulses. No queuing.
- `alu_a`, `alu_b` and `alu_fun` hold their values between frames. `CMD_ALU_NOP` reuses the stored operands.
- `alu_fun` is stable from GET_FUN exit until the next GET_FUN capture, so the decoder select never changes while `alu_en` is high.

## Timing
- Reset values: state IDLE; `alu_a`, `alu_b`, `alu_fun`, result and `tx_data` all 0; `alu_en`, `tx_valid` and `err` all 0.
- Reset asserted mid-frame or mid-send returns to IDLE immediately (asynchronous). No partial byte is replayed after reset.
- All outputs are registered.
- Cycle accounting:
  - The `alu_en` cycle is the cycle after the cycle in which the function byte's `rx_valid` is sampled.
  - The earliest accepted `alu_out_valid` is the cycle after `alu_en`.
  - `tx_valid` rises the cycle after `alu_out_valid`.
- Timeout: `err` pulses in the cycle after `RES_TIMEOUT` cycles of WAIT_RES with no `alu_out_valid`.
- If `alu_out_valid` arrives in the same cycle the count expires, the result wins and there is no `err`.
- `tx_valid` stays high across the LO->HI transition. The HI byte is presented the cycle after the LO byte is accepted.
- `tx_valid` drops the cycle after the HI byte is accepted.
- A held `tx_busy` stalls indefinitely with `tx_data` stable. No timeout applies in the SEND states.
- `alu_out_valid` outside WAIT_RES is ignored.

## Structure
- Shared system-controller package holds:
  - the state encoding (3-bit localparams);
  - default opcodes `CMD_ALU_OP` and `CMD_ALU_NOP`;
  - the ALU unit select codes: 00 arith, 01 logic, 10 cmp, 11 shift.
- Single module. No sub-module is needed.
- The timeout counter is `$clog2(RES_TIMEOUT+1)` bits wide.

## Test plan
- **Full OP frame, ALU replies immediately:** frame CC, 05, 03, 00; ALU replies 0x0008 the cycle after `alu_en`. Required: one `alu_en` pulse with `alu_fun = 0000`, `alu_a = 05`, `alu_b = 03`; TX bytes 08 then 00; no `err`.
- **NOP frame on stored operands:** frame DD, 0x0D following the previous frame. Required: `alu_fun = 1101` (decoder select 11, shift unit); operands still 05/03; result 0x1234 sent as 34 then 12.
- **Unknown opcode:** byte 0x7A in IDLE. Required: `err` pulse; state stays IDLE; a following CC frame completes normally.
- **Result timeout:** no `alu_out_valid` after EXEC. Required: `err` exactly `RES_TIMEOUT+1` cycles after `alu_en`; no `tx_valid`; return to IDLE.
- **Transmitter back-pressure with a dropped byte:** `tx_busy` high for 10 cycles in SEND_LO, and an `rx_valid` arrives during the stall. Required: `tx_data` held at the LO byte; `err` pulse for the dropped byte; LO then HI accepted after `tx_busy` falls.
- **Reset mid-frame:** `rst_n` low after GET_B. Required: all outputs return to reset values at once; the next frame after release is decoded from IDLE.
